kbd_ps2_scan: RTL
=================

Name: kbd_ps2_scan

Overview:
- Upstream stage of the keyboard path. Receives raw PS/2 set-2 frames from the keyboard pins and strips the E0/F0/E1 prefixes.
- Tracks the left-shift state and emits one strobe per make code.
- Its code_out and shift_out feed the scancode-to-BK-code translator (incode, shift) directly. Break codes and prefixes never reach the translator.

Parameters:
- FILT_LEN, 8, consecutive equal synchronized samples required before the filtered ps2_clk level changes.
- TIMEOUT, 50000, clk cycles of ps2_clk inactivity mid-frame before the frame is aborted (2 ms at 25 MHz).

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous reset, active-high.
- ps2_clk  in  1  keyboard clock pin, asynchronous.
- ps2_dat  in  1  keyboard data pin, asynchronous.
- code_out  out  8  make scancode, prefix stripped; held until the next strobe.
- shift_out  out  1  left-shift state captured with code_out.
- ext_out  out  1  1 if code_out was E0-prefixed.
- code_valid  out  1  one-cycle strobe; code_out/shift_out/ext_out valid in the same cycle.
- err  out  1  one-cycle pulse on parity, start, stop or timeout error.

Behaviour:
- Reset: all outputs 0, shift state 0, prefix flags 0, skip counter 0, receiver in IDLE. Reset mid-frame discards the partial byte.
- Input conditioning:
  - ps2_clk and ps2_dat each pass through a 2-FF synchronizer.
  - Filtered clock flips only after FILT_LEN equal samples.
  - A filtered 1->0 transition samples synchronized ps2_dat.
- Frame receiver FSM (IDLE, DATA, PARITY, STOP):
  - IDLE: sampled 0 -> DATA with bit count 0. Sampled 1 -> stay in IDLE, no error.
  - DATA: 8 bits, LSB first; after bit 7 -> PARITY.
  - PARITY: the captured bit must make the total odd over the 8 data bits plus parity.
  - STOP: the bit must be 1. Good frame -> byte_rdy pulse in the cycle after the stop sample, then IDLE.
  - Bad parity or stop -> err pulse, byte discarded, prefix flags cleared, IDLE.
  - Timeout: counter resets on every filtered clock edge. Reaching TIMEOUT while not in IDLE -> err pulse, prefix flags cleared, IDLE. The timeout is ignored in IDLE.
- Byte decoder, on byte_rdy:
  - skip > 0: decrement skip, nothing else.
  - E1: skip = 7 (discards the Pause sequence).
  - E0: ext flag = 1.
  - F0: brk flag = 1.
  - FA, AA, EE, FC, FE, 00, FF with no prefix pending: ignored.
  - 12 with ext = 0: shift = ~brk, no emit.
  - 12 or 59 with ext = 1 (fake shifts): ignored, no emit.
  - Any other byte with brk = 0: code_valid = 1, code_out = byte, shift_out = current shift, ext_out = ext.
  - Any other byte with brk = 1: no emit.
  - After any non-prefix byte: ext = brk = 0.
- Latency: code_valid fires 2 clk cycles after the stop-bit sample edge is detected on the filtered clock.
- Typematic repeats: each repeated make byte produces its own strobe.
- Right shift (59), CapsLock (58) and all other keys are emitted as ordinary codes; only 12 drives shift.
- Simultaneous error and byte_rdy cannot occur (exclusive FSM exits).
- A reset asserted in the same cycle as byte_rdy wins: no strobe.

Decomposition:
- Package kbd_pkg:
  - Byte constants: PS2_E0 = 8'hE0, PS2_E1 = 8'hE1, PS2_F0 = 8'hF0, PS2_LSHIFT = 8'h12, PS2_RSHIFT = 8'h59.
  - Ignored replies: FA, AA, EE, FC, FE, 00, FF.
  - Receiver state enumeration.
- Sub-module ps2_rx_frame contains the synchronizers, filter, frame FSM and timeout. It outputs byte, byte_rdy and frame_err.
- kbd_ps2_scan holds the prefix/shift decoder and the output registers.

Test Plan:
- Frame 1C (a), correct parity 0 -> one code_valid, code_out = 8'h1C, shift_out = 0, ext_out = 0, err = 0.
- Sequence 12, 1C, F0 1C, F0 12, 1C -> two strobes: first 1C with shift_out = 1, second 1C with shift_out = 0. No strobe for any F0 byte or for 12.
- Sequence E0 75, E0 F0 75 (arrow up) -> single strobe: code_out = 8'h75, ext_out = 1. Then E0 12 E0 75 -> strobe 75, shift state unchanged.
- Frame 1C with parity bit inverted -> err pulse, no strobe. A following valid 16 -> strobe code_out = 8'h16.
- Pause sequence E1 14 77 E1 F0 14 F0 77, then 29 -> only one strobe, code_out = 8'h29.
- Start bit plus 3 data bits, then clock idle > TIMEOUT -> err pulse. A following valid 5A -> strobe 5A. A 3-cycle glitch on ps2_clk (< FILT_LEN) -> no bit sampled, frame still decodes correctly.

Source files
------------

// File: rtl/kbd_pkg.sv
// Shared constants and types for the PS/2 set-2 keyboard front end.
package kbd_pkg;

  localparam logic [7:0] PS2_E0     = 8'hE0;
  localparam logic [7:0] PS2_E1     = 8'hE1;
  localparam logic [7:0] PS2_F0     = 8'hF0;
  localparam logic [7:0] PS2_LSHIFT = 8'h12;
  localparam logic [7:0] PS2_RSHIFT = 8'h59;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_DATA,
    RX_PARITY,
    RX_STOP
  } rx_state_e;

  // Keyboard replies / self-test results that carry no key information.
  function automatic logic is_reply(input logic [7:0] b);
    return (b == 8'hFA) || (b == 8'hAA) || (b == 8'hEE) || (b == 8'hFC) ||
           (b == 8'hFE) || (b == 8'h00) || (b == 8'hFF);
  endfunction

endpackage

// File: rtl/ps2_rx_frame.sv
// PS/2 frame receiver: pin synchronizers, clock glitch filter, 11-bit frame FSM
// and mid-frame inactivity timeout. Emits one byte per good frame.
module ps2_rx_frame
  import kbd_pkg::*;
#(
  parameter int FILT_LEN = 8,
  parameter int TIMEOUT  = 50000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ps2_clk_i,
  input  logic       ps2_dat_i,
  output logic [7:0] rx_byte_o,
  output logic       byte_rdy_o,
  output logic       frame_err_o
);

  localparam int FW = $clog2(FILT_LEN + 1);
  localparam int TW = $clog2(TIMEOUT + 1);

  logic [1:0]    clk_sync_q, dat_sync_q;
  logic          filt_q;
  logic [FW-1:0] fcnt_q;
  logic          clk_s, samp, flip, fall, to_hit;
  rx_state_e     state_q, state_d;
  logic [7:0]    shreg_q;
  logic [2:0]    bcnt_q;
  logic          par_q;
  logic [TW-1:0] to_q;
  logic          rdy_d, err_d, rdy_q, err_q;

  assign clk_s = clk_sync_q[1];
  assign samp  = dat_sync_q[1];

  always_ff @(posedge clk) begin
    if (reset) begin
      clk_sync_q <= 2'b11;
      dat_sync_q <= 2'b11;
    end else begin
      clk_sync_q <= {clk_sync_q[0], ps2_clk_i};
      dat_sync_q <= {dat_sync_q[0], ps2_dat_i};
    end
  end

  // Filtered level follows only after FILT_LEN consecutive differing samples.
  assign flip = (clk_s != filt_q) && (fcnt_q == FW'(FILT_LEN - 1));
  assign fall = flip && filt_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      filt_q <= 1'b1;
      fcnt_q <= '0;
    end else if (clk_s == filt_q) begin
      fcnt_q <= '0;
    end else if (flip) begin
      filt_q <= clk_s;
      fcnt_q <= '0;
    end else begin
      fcnt_q <= fcnt_q + 1'b1;
    end
  end

  assign to_hit = (state_q != RX_IDLE) && !flip && (to_q == TW'(TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (reset || flip || state_q == RX_IDLE) to_q <= '0;
    else                                     to_q <= to_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) state_q <= RX_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (to_hit) begin
      state_d = RX_IDLE;
    end else if (fall) begin
      case (state_q)
        RX_IDLE:   if (!samp) state_d = RX_DATA;
        RX_DATA:   if (bcnt_q == 3'd7) state_d = RX_PARITY;
        RX_PARITY: state_d = RX_STOP;
        default:   state_d = RX_IDLE;
      endcase
    end
  end

  always_comb begin
    rdy_d = 1'b0;
    err_d = 1'b0;
    if (to_hit) begin
      err_d = 1'b1;
    end else if (fall && state_q == RX_STOP) begin
      // Odd parity over data + parity bit, and stop bit must be high.
      if (samp && (^shreg_q ^ par_q)) rdy_d = 1'b1;
      else                            err_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      shreg_q <= '0;
      bcnt_q  <= '0;
      par_q   <= 1'b0;
    end else if (fall) begin
      case (state_q)
        RX_IDLE: bcnt_q <= '0;
        RX_DATA: begin
          shreg_q <= {samp, shreg_q[7:1]};
          bcnt_q  <= bcnt_q + 1'b1;
        end
        RX_PARITY: par_q <= samp;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rdy_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      rdy_q <= rdy_d;
      err_q <= err_d;
    end
  end

  assign rx_byte_o   = shreg_q;
  assign byte_rdy_o  = rdy_q;
  assign frame_err_o = err_q;

endmodule

// File: rtl/kbd_ps2_scan.sv
// PS/2 scan front end: strips E0/F0/E1 prefixes, tracks left shift and
// strobes one make code per key press toward the scancode translator.
module kbd_ps2_scan
  import kbd_pkg::*;
#(
  parameter int FILT_LEN = 8,
  parameter int TIMEOUT  = 50000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ps2_clk,
  input  logic       ps2_dat,
  output logic [7:0] code_out,
  output logic       shift_out,
  output logic       ext_out,
  output logic       code_valid,
  output logic       err
);

  logic [7:0] rx_byte;
  logic       rx_rdy, rx_err;

  logic [7:0] code_q, code_d;
  logic       shout_q, shout_d, extout_q, extout_d, vld_q, vld_d;
  logic       shift_q, shift_d, ext_q, ext_d, brk_q, brk_d;
  logic [2:0] skip_q, skip_d;
  logic       fake_shift;

  ps2_rx_frame #(
    .FILT_LEN(FILT_LEN),
    .TIMEOUT (TIMEOUT)
  ) u_rx (
    .clk        (clk),
    .reset      (reset),
    .ps2_clk_i  (ps2_clk),
    .ps2_dat_i  (ps2_dat),
    .rx_byte_o  (rx_byte),
    .byte_rdy_o (rx_rdy),
    .frame_err_o(rx_err)
  );

  assign fake_shift = ext_q && (rx_byte == PS2_LSHIFT || rx_byte == PS2_RSHIFT);

  always_comb begin
    code_d   = code_q;
    shout_d  = shout_q;
    extout_d = extout_q;
    vld_d    = 1'b0;
    shift_d  = shift_q;
    ext_d    = ext_q;
    brk_d    = brk_q;
    skip_d   = skip_q;
    if (rx_err) begin
      ext_d = 1'b0;
      brk_d = 1'b0;
    end else if (rx_rdy) begin
      if (skip_q != 3'd0) begin
        skip_d = skip_q - 1'b1;
      end else if (rx_byte == PS2_E1) begin
        // Pause: E1 is followed by seven bytes that carry nothing useful.
        skip_d = 3'd7;
      end else if (rx_byte == PS2_E0) begin
        ext_d = 1'b1;
      end else if (rx_byte == PS2_F0) begin
        brk_d = 1'b1;
      end else begin
        ext_d = 1'b0;
        brk_d = 1'b0;
        if (!(is_reply(rx_byte) && !ext_q && !brk_q)) begin
          if (rx_byte == PS2_LSHIFT && !ext_q) begin
            shift_d = ~brk_q;
          end else if (!fake_shift && !brk_q) begin
            vld_d    = 1'b1;
            code_d   = rx_byte;
            shout_d  = shift_q;
            extout_d = ext_q;
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      code_q   <= '0;
      shout_q  <= 1'b0;
      extout_q <= 1'b0;
      vld_q    <= 1'b0;
      shift_q  <= 1'b0;
      ext_q    <= 1'b0;
      brk_q    <= 1'b0;
      skip_q   <= '0;
    end else begin
      code_q   <= code_d;
      shout_q  <= shout_d;
      extout_q <= extout_d;
      vld_q    <= vld_d;
      shift_q  <= shift_d;
      ext_q    <= ext_d;
      brk_q    <= brk_d;
      skip_q   <= skip_d;
    end
  end

  assign code_out   = code_q;
  assign shift_out  = shout_q;
  assign ext_out    = extout_q;
  assign code_valid = vld_q;
  assign err        = rx_err;

endmodule
